aes_cipher_iter: RTL and testbench

AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_cipher_iter_if.sv | 31 +++
 rtl/aes_round.sv | 43 ++++
 rtl/aes_cipher_iter.sv | 96 +++++++++
 tb/tb_aes_cipher_iter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: block type, FSM states, GF(2^8) helpers.
// Used by the iterative cipher and the key-expansion stage.
package aes_pkg;

  localparam int ROUNDS = 10;

  typedef logic [0:127] block_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Inverse is b^254 by square-and-multiply, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] e;
    logic [7:0] r;
    e = 8'hfe;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, b);
    end
    return r ^ {r[6:0], r[7]}
             ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Plaintext-in / ciphertext-out handshake bundle.
// master drives plaintext and takes ciphertext.
interface aes_cipher_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t plaintext;
  logic   out_valid;
  logic   out_ready;
  block_t ciphertext;

  modport master (
    output in_valid,
    output plaintext,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  ciphertext
  );

  modport slave (
    input  in_valid,
    input  plaintext,
    input  out_ready,
    output in_ready,
    output out_valid,
    output ciphertext
  );

endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows,
// MixColumns (skipped on the final round), AddRoundKey.
module aes_round
  import aes_pkg::*;
(
  input  block_t state_i,
  input  block_t rkey_i,
  input  logic   final_i,
  output block_t state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(state_i[8*i +: 8]);
    end
    // byte index = 4*col + row; row r rotates left by r
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1])
                ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1])
                ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    state_o = '0;
    for (int i = 0; i < 16; i++) begin
      state_o[8*i +: 8] = (final_i ? sr[i] : mc[i])
                        ^ rkey_i[8*i +: 8];
    end
  end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: one round per clock,
// 10 cycles from accept to ciphertext valid.
module aes_cipher_iter
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  block_t                plaintext,
  input  logic [0:ROUNDS][0:127] fullkeys,
  output logic                  out_valid,
  input  logic                  out_ready,
  output block_t                ciphertext
);

  fsm_e       fsm_q, fsm_d;
  logic [3:0] round_q, round_d;
  block_t     state_q, state_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;

  block_t     round_state;
  logic       last_round;

  assign last_round = (round_q == 4'(ROUNDS));

  aes_round u_round (
    .state_i (state_q),
    .rkey_i  (fullkeys[round_q]),
    .final_i (last_round),
    .state_o (round_state)
  );

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          fsm_d      = ROUND;
          round_d    = 4'd1;
          state_d    = plaintext ^ fullkeys[0];
          in_ready_d = 1'b0;
        end
      end
      ROUND: begin
        state_d = round_state;
        if (last_round) begin
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d       = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        fsm_d       = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      round_q     <= 4'd0;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: known answers, stall, ignore,
// mid-flight reset, back-to-back and random blocks vs a model.
module tb_aes_cipher_iter;
  import aes_pkg::*;

  typedef logic [0:10][0:127] keys_t;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic  clk = 1'b0;
  logic  rst;
  keys_t fk;
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;

  logic [7:0] sb_t [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_iter_if bus ();

  aes_cipher_iter #(.ROUNDS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .plaintext  (bus.plaintext),
    .fullkeys   (fk),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .ciphertext (bus.ciphertext)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // S-box from the generator-3 walk over GF(2^8)
  function automatic void build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb_t[0] = 8'h63;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  function automatic keys_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    keys_t       k;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_t[t[31:24]], sb_t[t[23:16]],
             sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction

  function automatic logic [127:0] encrypt(input keys_t k,
                                           input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ k[0];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_t[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 10) ? t[4*c+r] :
                     gmul(8'h02, t[4*c+r])
                     ^ gmul(8'h03, t[4*c+(r+1)%4])
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk = blk ^ k[rd];
    end
    return blk;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rdy"}, bus.in_ready, 1);
  endtask

  task automatic do_block(input logic [127:0] key,
                          input logic [127:0] pt,
                          input int hold,
                          input bit inject,
                          input logic [127:0] known,
                          input bit has_known,
                          input string tag);
    int n;
    bit bad;
    logic [127:0] exp;
    fk  = expand(key);
    exp = encrypt(fk, pt);
    wait_ready(tag);
    bus.out_ready = 1'b0;
    bus.plaintext = pt;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.plaintext = rnd128();
    n = 0;
    bad = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) bad = 1;
      bus.in_valid = inject && (n == 3);
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_lat"}, n, 10);
    check({tag, "_busy"}, bad, 0);
    check({tag, "_ct"}, bus.ciphertext, exp);
    if (has_known) check({tag, "_kat"}, bus.ciphertext, known);
    bad = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready ||
          bus.ciphertext !== exp) bad = 1;
    end
    if (hold > 0) check({tag, "_stall"}, bad, 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_cmpl"}, {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  task automatic back_to_back();
    logic [127:0] a, b, ea, eb;
    int t0, t1, n;
    fk = expand(K2);
    a  = rnd128();
    b  = rnd128();
    ea = encrypt(fk, a);
    eb = encrypt(fk, b);
    wait_ready("b2b");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.plaintext = a;
    @(posedge clk); #1;
    t0 = cyc;
    bus.plaintext = b;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_ct_a", bus.ciphertext, ea);
    t1 = 0;
    n = 0;
    while (n < 40) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        t1 = cyc;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    check("b2b_gap", t1 - t0, 12);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_ct_b", bus.ciphertext, eb);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_end", {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    build_sbox();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    fk            = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ct", bus.ciphertext, 0);

    do_block(K1, P1, 0, 1'b0, C1, 1'b1, "kat1");
    do_block(K2, P2, 20, 1'b0, C2, 1'b1, "kat2");
    do_block(K1, P1, 0, 1'b1, C1, 1'b1, "ignore");

    // abort a block around round 5
    fk = expand(K2);
    wait_ready("abort");
    bus.plaintext = P2;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_state", {bus.in_ready, bus.out_valid}, 2'b10);
    check("abort_ct", bus.ciphertext, 0);
    do_block(K1, P1, 0, 1'b0, C1, 1'b1, "after_abort");

    back_to_back();

    for (int i = 0; i < 6; i++) begin
      do_block(rnd128(), rnd128(), $urandom_range(0, 4),
               1'($urandom_range(0, 1)), '0, 1'b0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
